// File: rtl/mac_accum_readout_if.sv
// Product intake, command and byte-serial readout signals of the MAC accumulator.
// The master side is the upstream stage and the readout consumer. The slave side is the accumulator.
interface mac_accum_readout_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic [PROD_W-1:0] prod_i;
  logic              prod_valid_i;
  logic              prod_ready_o;
  logic              clr_i;
  logic              rd_req_i;
  logic [7:0]        dout_o;
  logic              dout_valid_o;
  logic              dout_last_o;
  logic [ACC_W-1:0]  acc_o;
  logic [CNT_W-1:0]  cnt_o;
  logic              sat_o;

  modport master (
    output prod_i, prod_valid_i, clr_i, rd_req_i,
    input  prod_ready_o, dout_o, dout_valid_o, dout_last_o, acc_o, cnt_o, sat_o
  );

  modport slave (
    input  prod_i, prod_valid_i, clr_i, rd_req_i,
    output prod_ready_o, dout_o, dout_valid_o, dout_last_o, acc_o, cnt_o, sat_o
  );
endinterface

// File: rtl/mac_accum_readout.sv
// Saturating product accumulator with a snapshot readout that emits one byte per cycle, LSB first.
// Product intake stalls while a readout is in flight.
module mac_accum_readout #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_accum_readout_if.slave    bus
);

  localparam int NBYTES = ACC_W / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(NBYTES - 1);

  typedef enum logic {ACC, READ} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sat, sat_nxt;
  logic [ACC_W-1:0]  shift, shifted;
  logic [BC_W-1:0]   bcnt;
  logic [7:0]        dout;
  logic              dout_valid, dout_last, prod_ready;
  logic              accepted;
  logic [ACC_W:0]    sum;

  // Top bit of the result is the overflow flag. On overflow the value clamps to all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    accepted = bus.prod_valid_i & (state == ACC);
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    sat_nxt  = sat;
    sum      = '0;
    if (state == ACC) begin
      if (bus.clr_i) begin
        acc_nxt = accepted ? ACC_W'(bus.prod_i) : '0;
        cnt_nxt = accepted ? CNT_W'(1) : '0;
        sat_nxt = 1'b0;
      end else if (accepted) begin
        sum     = sat_add(acc, bus.prod_i);
        acc_nxt = sum[ACC_W-1:0];
        sat_nxt = sat | sum[ACC_W];
        cnt_nxt = sat_inc(cnt);
      end
    end
    shifted = shift >> 8;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      shift      <= '0;
      bcnt       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      sat <= sat_nxt;
      case (state)
        ACC: begin
          // The snapshot includes any clear or product that lands in the same cycle.
          if (bus.rd_req_i) begin
            state      <= READ;
            shift      <= acc_nxt;
            bcnt       <= '0;
            dout       <= acc_nxt[7:0];
            dout_valid <= 1'b1;
            dout_last  <= (NBYTES == 1);
            prod_ready <= 1'b0;
          end
        end
        READ: begin
          if (bcnt == LAST_IDX) begin
            state      <= ACC;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            prod_ready <= 1'b1;
          end else begin
            shift     <= shifted;
            bcnt      <= bcnt + 1'b1;
            dout      <= shifted[7:0];
            dout_last <= ((bcnt + 1'b1) == LAST_IDX);
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.prod_ready_o = prod_ready;
  assign bus.dout_o       = dout;
  assign bus.dout_valid_o = dout_valid;
  assign bus.dout_last_o  = dout_last;
  assign bus.acc_o        = acc;
  assign bus.cnt_o        = cnt;
  assign bus.sat_o        = sat;

endmodule

// File: doc/mac_accum_readout.md
Name: mac_accum_readout

Overview:
- Downstream stage of the 8x8 nibble-loaded multiplier. Sums a stream of full-width products into a wide saturating accumulator.
- On request, snapshots the accumulator and streams it out one byte per cycle, LSB first, so it fits an 8-bit output pin bank.
- Products enter through a valid/ready handshake; the block stalls product intake while a readout is in progress.

Parameters:
- PROD_W, 16, product input width (full 8x8 result, no truncation).
- ACC_W, 24, accumulator width; must be a multiple of 8 and >= PROD_W.
- CNT_W, 8, width of the accumulated-product counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- prod_i  in  PROD_W  unsigned product from multiplier.
- prod_valid_i  in  1  prod_i valid this cycle.
- prod_ready_o  out  1  block accepts product this cycle.
- clr_i  in  1  clear accumulator, count and saturation flag.
- rd_req_i  in  1  start byte-serial readout.
- dout_o  out  8  readout byte.
- dout_valid_o  out  1  dout_o valid.
- dout_last_o  out  1  final byte of readout.
- acc_o  out  ACC_W  live accumulator value.
- cnt_o  out  CNT_W  number of products accumulated since clear; saturates at all-ones.
- sat_o  out  1  sticky accumulator-saturation flag.

Behaviour:
- Reset is synchronous on rst_n low. It is sampled at the clk edge and overrides everything, including an in-progress readout.
  - state=ACC; acc, cnt, sat, shift register, byte counter all 0.
  - dout_o=0, dout_valid_o=0, dout_last_o=0, prod_ready_o=1 after reset.
- States: ACC (accumulating), READ (streaming bytes). NBYTES = ACC_W/8.
- prod_ready_o = (state==ACC). A product is accepted when prod_valid_i & prod_ready_o.
- ACC, clr_i=1:
  - acc <= accepted ? zero-extended prod_i : 0.
  - cnt <= accepted ? 1 : 0.
  - sat <= 0.
- ACC, clr_i=0, accepted:
  - sum = acc + prod_i, computed in ACC_W+1 bits.
  - If the carry bit is set: acc <= all-ones and sat <= 1. Otherwise acc <= sum[ACC_W-1:0].
  - Once acc is all-ones, further additions hold acc at all-ones.
  - cnt <= cnt+1, holding at all-ones (no wrap).
- ACC, rd_req_i=1:
  - Next state is READ.
  - Shift register loads acc_next, i.e. the value after any same-cycle clear and/or accepted product.
  - Byte counter <= 0.
- READ:
  - dout_valid_o=1. dout_o = shift register [7:0].
  - Each cycle the shift register shifts right by 8 and the byte counter increments.
  - dout_last_o=1 when byte counter == NBYTES-1; next state is ACC.
  - No backpressure on dout.
  - In READ, rd_req_i and clr_i are ignored and not queued. acc, cnt and sat hold.
- Timing:
  - Latency is 1 cycle: first byte appears the cycle after rd_req_i is sampled.
  - Bytes occupy NBYTES consecutive cycles.
  - prod_ready_o returns high the cycle after dout_last_o.
- dout_o is 0 whenever dout_valid_o=0.
- acc_o, cnt_o and sat_o are direct register outputs, updated the cycle after the causing event.
- A product offered while prod_ready_o=0 is not consumed. The upstream stage must hold prod_i and prod_valid_i.

Test Plan:
- Basic accumulate/readout: reset, accept 0x4E20 (200x100) three times, pulse rd_req_i → acc_o=0x00EA60, cnt_o=3. Bytes 0x60, 0xEA, 0x00 in three consecutive cycles, dout_last_o on 0x00, prod_ready_o high next cycle.
- Saturation: feed 0xFFFF continuously → after 256 products acc_o=0xFFFF00, sat_o=0. On the 257th: acc_o=0xFFFFFF, sat_o=1. Further products keep acc_o=0xFFFFFF, and cnt_o stops at 255.
- Clear with simultaneous product: acc=0x001234, sat=1; clr_i=1 with valid prod_i=0x0010 → acc_o=0x000010, cnt_o=1, sat_o=0.
- Stall and same-cycle read:
  - rd_req_i in the same cycle as an accepted prod_i=0x0005 on acc=0x000100 → streamed bytes 0x05, 0x01, 0x00.
  - prod_i=0x0007 held valid during READ is not accepted (prod_ready_o=0 for 3 cycles).
  - It is accepted in the cycle after dout_last_o → acc_o=0x00010C.
- Ignored commands: clr_i and rd_req_i asserted during READ byte 2 → acc unchanged, readout completes normally, no second readout follows.
- Reset mid-readout: rst_n low during byte 2 → next cycle dout_valid_o=0, dout_o=0, acc_o=0, cnt_o=0, sat_o=0, prod_ready_o=1.
